// File: rtl/gc_pb_iteration_scheduler.sv
// Program-block iteration scheduler: walks each configured block through its
// iteration count and presents the live iteration in that block's bus slot.
module gc_pb_iteration_scheduler #(
  parameter int MAX_NO_OF_PROGRAM_BLOCKS = 12,
  parameter int ITERATION_VARIABLE_WIDTH = 16,
  parameter int PB_SEL_WIDTH             = 4
) (
  input  logic                                                              clk,
  input  logic                                                              reset_n,
  input  logic                                                              cfg_we,
  input  logic [PB_SEL_WIDTH-1:0]                                           cfg_addr,
  input  logic [ITERATION_VARIABLE_WIDTH-1:0]                               cfg_count,
  input  logic [PB_SEL_WIDTH-1:0]                                           num_blocks,
  input  logic                                                              start,
  input  logic                                                              stall,
  output logic signed [0:MAX_NO_OF_PROGRAM_BLOCKS*ITERATION_VARIABLE_WIDTH-1] iter_out,
  output logic [MAX_NO_OF_PROGRAM_BLOCKS-1:0]                               pb_active,
  output logic                                                              iter_valid,
  output logic                                                              busy,
  output logic                                                              done
);

  localparam int N = MAX_NO_OF_PROGRAM_BLOCKS;
  localparam int W = ITERATION_VARIABLE_WIDTH;
  localparam logic [PB_SEL_WIDTH-1:0] N_SEL    = PB_SEL_WIDTH'(N);
  localparam logic [PB_SEL_WIDTH-1:0] LAST_SEL = PB_SEL_WIDTH'(N - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t                  state;
  logic [PB_SEL_WIDTH-1:0] pb_idx;
  logic [PB_SEL_WIDTH-1:0] last_idx;
  logic [W-1:0]            iter;
  logic [W-1:0]            count_tbl [N];

  logic [W-1:0]            cur_count;
  logic                    step_done;
  logic [PB_SEL_WIDTH-1:0] clamped_last;

  assign cur_count = count_tbl[pb_idx];
  // A zero-count block consumes exactly one cycle, stall or not.
  assign step_done = (cur_count == '0) || (!stall && (iter == cur_count - W'(1)));
  assign clamped_last = (num_blocks >= N_SEL) ? LAST_SEL : (num_blocks - PB_SEL_WIDTH'(1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < N; i++) begin
        count_tbl[i] <= '0;
      end
    end else if (cfg_we && (state == IDLE) && (cfg_addr < N_SEL)) begin
      count_tbl[cfg_addr] <= cfg_count;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      pb_idx   <= '0;
      iter     <= '0;
      last_idx <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            last_idx <= clamped_last;
            pb_idx   <= '0;
            iter     <= '0;
            state    <= (num_blocks == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          if (step_done) begin
            iter <= '0;
            if (pb_idx == last_idx) begin
              pb_idx <= '0;
              state  <= DONE;
            end else begin
              pb_idx <= pb_idx + PB_SEL_WIDTH'(1);
            end
          end else if (!stall) begin
            iter <= iter + W'(1);
          end
        end
        DONE: begin
          pb_idx <= '0;
          iter   <= '0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    iter_out  = '0;
    pb_active = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if ((state == RUN) && (pb_idx == PB_SEL_WIDTH'(i))) begin
        iter_out[i*W +: W] = iter;
        pb_active[i]       = 1'b1;
      end
    end
  end

  assign iter_valid = (state == RUN) && (cur_count != '0);
  assign busy       = (state != IDLE);
  assign done       = (state == DONE);

endmodule

// File: tb/tb_gc_pb_iteration_scheduler.sv
// Randomised scoreboard bench for gc_pb_iteration_scheduler, plus a narrow-width
// instance exercising the no-wrap boundary.
module tb_gc_pb_iteration_scheduler;

  localparam int N  = 12;
  localparam int W  = 16;
  localparam int PB = 4;
  localparam int W4 = 4;

  typedef struct packed {
    logic [0:N*W-1] io;
    logic [N-1:0]   act;
    logic           v;
    logic           b;
    logic           d;
  } exp_t;

  logic                  clk = 1'b0;
  logic                  reset_n = 1'b1;
  logic                  cfg_we = 1'b0;
  logic [PB-1:0]         cfg_addr = '0;
  logic [W-1:0]          cfg_count = '0;
  logic [PB-1:0]         num_blocks = '0;
  logic                  start = 1'b0;
  logic                  stall = 1'b0;
  logic signed [0:N*W-1] iter_out;
  logic [N-1:0]          pb_active;
  logic                  iter_valid, busy, done;

  logic                   cfg_we4 = 1'b0;
  logic [PB-1:0]          cfg_addr4 = '0;
  logic [W4-1:0]          cfg_count4 = '0;
  logic [PB-1:0]          num4 = '0;
  logic                   start4 = 1'b0;
  logic                   stall4 = 1'b0;
  logic signed [0:N*W4-1] iter_out4;
  logic [N-1:0]           pb_active4;
  logic                   valid4, busy4, done4;

  int          total = 0;
  int          bad = 0;
  exp_t        q[$];
  logic [W-1:0] mtbl [N];
  bit          stall_arr [512];
  bit          mon_en = 1'b0;

  gc_pb_iteration_scheduler #(
    .MAX_NO_OF_PROGRAM_BLOCKS(N),
    .ITERATION_VARIABLE_WIDTH(W),
    .PB_SEL_WIDTH(PB)
  ) u_dut (
    .clk(clk), .reset_n(reset_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_count(cfg_count), .num_blocks(num_blocks), .start(start), .stall(stall),
    .iter_out(iter_out), .pb_active(pb_active), .iter_valid(iter_valid),
    .busy(busy), .done(done)
  );

  gc_pb_iteration_scheduler #(
    .MAX_NO_OF_PROGRAM_BLOCKS(N),
    .ITERATION_VARIABLE_WIDTH(W4),
    .PB_SEL_WIDTH(PB)
  ) u_dut4 (
    .clk(clk), .reset_n(reset_n), .cfg_we(cfg_we4), .cfg_addr(cfg_addr4),
    .cfg_count(cfg_count4), .num_blocks(num4), .start(start4), .stall(stall4),
    .iter_out(iter_out4), .pb_active(pb_active4), .iter_valid(valid4),
    .busy(busy4), .done(done4)
  );

  always #5 clk = ~clk;

  function automatic bit stall_at(int t);
    return (t < 512) ? stall_arr[t] : 1'b0;
  endfunction

  function automatic exp_t mk_item(int b, int v, bit valid);
    exp_t e;
    e = '0;
    e.act[b] = 1'b1;
    e.b = 1'b1;
    e.v = valid;
    if (valid) e.io[b*W +: W] = W'(v);
    return e;
  endfunction

  // Expected cycle-by-cycle view of one run; returns the number of RUN cycles.
  function automatic int build_run(int nb);
    int   n;
    int   t;
    exp_t e;
    n = (nb > N) ? N : nb;
    t = 0;
    for (int b = 0; b < n; b++) begin
      if (mtbl[b] == '0) begin
        q.push_back(mk_item(b, 0, 1'b0));
        t++;
      end else begin
        for (int v = 0; v < int'(mtbl[b]); v++) begin
          while (stall_at(t)) begin
            q.push_back(mk_item(b, v, 1'b1));
            t++;
          end
          q.push_back(mk_item(b, v, 1'b1));
          t++;
        end
      end
    end
    e = '0;
    e.b = 1'b1;
    e.d = 1'b1;
    q.push_back(e);
    return t;
  endfunction

  always @(negedge clk) begin : monitor
    exp_t e;
    exp_t a;
    if (mon_en) begin
      e = '0;
      if (q.size() > 0) e = q.pop_front();
      a.io  = iter_out;
      a.act = pb_active;
      a.v   = iter_valid;
      a.b   = busy;
      a.d   = done;
      total++;
      if (a !== e) begin
        bad++;
        $display("FAIL cycle @%0t: got io=%h act=%h v=%b busy=%b done=%b want io=%h act=%h v=%b busy=%b done=%b",
                 $time, a.io, a.act, a.v, a.b, a.d, e.io, e.act, e.v, e.b, e.d);
      end
    end
  end

  task automatic write_cfg(int addr, int val);
    cfg_we    = 1'b1;
    cfg_addr  = 4'(addr);
    cfg_count = W'(val);
    @(posedge clk); #1;
    cfg_we = 1'b0;
    if (addr < N) mtbl[addr] = W'(val);
  endtask

  task automatic set_stalls(bit rnd);
    for (int t = 0; t < 512; t++) stall_arr[t] = rnd ? ($urandom % 4 == 0) : 1'b0;
  endtask

  task automatic do_run(int nb, bit noise);
    int len;
    num_blocks = 4'(nb);
    start = 1'b1;
    @(posedge clk); #1;
    len = build_run(nb);
    start = 1'b0;
    for (int t = 0; t < len; t++) begin
      stall = stall_at(t);
      if (noise) begin
        start     = ($urandom % 4 == 0);
        cfg_we    = ($urandom % 3 == 0);
        cfg_addr  = 4'($urandom % 16);
        cfg_count = W'($urandom_range(7, 9));
      end
      @(posedge clk); #1;
    end
    stall     = 1'b0;
    start     = noise;
    cfg_we    = noise;
    cfg_addr  = '0;
    cfg_count = W'(9);
    @(posedge clk); #1;
    start  = 1'b0;
    cfg_we = 1'b0;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: left=%0d want=0", q.size());
      q.delete();
    end
  endtask

  initial begin
    logic [0:N*W4-1] e4;
    for (int i = 0; i < N; i++) mtbl[i] = '0;
    set_stalls(1'b0);
    #1 reset_n = 1'b0;
    #2;
    total++;
    if (iter_out !== '0 || pb_active !== '0 || iter_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: got io=%h act=%h v=%b b=%b d=%b want all 0",
               iter_out, pb_active, iter_valid, busy, done);
    end
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    mon_en = 1'b1;
    @(posedge clk); #1;

    write_cfg(0, 3);
    write_cfg(1, 2);
    do_run(2, 1'b0);

    write_cfg(0, 4);
    stall_arr[1] = 1'b1;
    stall_arr[2] = 1'b1;
    do_run(1, 1'b0);
    set_stalls(1'b0);

    write_cfg(0, 2);
    write_cfg(1, 0);
    write_cfg(2, 1);
    do_run(3, 1'b0);

    do_run(3, 1'b1);
    do_run(3, 1'b0);

    for (int i = 0; i < N; i++) write_cfg(i, $urandom_range(0, 3));
    write_cfg(13, 7);
    do_run(15, 1'b1);
    do_run(0, 1'b0);

    repeat (25) begin
      repeat ($urandom_range(0, 3)) write_cfg($urandom_range(0, 15), $urandom_range(0, 5));
      set_stalls(1'b1);
      do_run($urandom_range(0, 15), 1'b1);
    end
    set_stalls(1'b0);

    write_cfg(0, 5);
    mon_en = 1'b0;
    num_blocks = 4'(1);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    total++;
    if (iter_out[0:W-1] !== W'(2) || iter_valid !== 1'b1) begin
      bad++;
      $display("FAIL pre_reset_iter: got slot0=%0d v=%b want slot0=2 v=1", iter_out[0:W-1], iter_valid);
    end
    #2 reset_n = 1'b0;
    #1;
    total++;
    if (iter_out !== '0 || pb_active !== '0 || iter_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL async_reset: got io=%h act=%h v=%b b=%b d=%b want all 0",
               iter_out, pb_active, iter_valid, busy, done);
    end
    for (int i = 0; i < N; i++) mtbl[i] = '0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    mon_en = 1'b1;
    do_run(1, 1'b0);
    do_run(12, 1'b0);

    // Narrow instance: count 2^W4-1 must climb to 14 and stop without wrapping.
    cfg_we4 = 1'b1;
    cfg_addr4 = '0;
    cfg_count4 = 4'd15;
    @(posedge clk); #1;
    cfg_we4 = 1'b0;
    num4 = 4'd1;
    start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    for (int v = 0; v < 15; v++) begin
      @(negedge clk);
      e4 = '0;
      e4[0:W4-1] = 4'(v);
      total++;
      if (iter_out4 !== e4 || valid4 !== 1'b1 || pb_active4 !== 12'h001 || busy4 !== 1'b1 || done4 !== 1'b0) begin
        bad++;
        $display("FAIL w4_iter%0d: got io=%h v=%b act=%h b=%b d=%b want io=%h v=1 act=001 b=1 d=0",
                 v, iter_out4, valid4, pb_active4, busy4, done4, e4);
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    total++;
    if (done4 !== 1'b1 || busy4 !== 1'b1 || valid4 !== 1'b0 || iter_out4 !== '0) begin
      bad++;
      $display("FAIL w4_done: got d=%b b=%b v=%b io=%h want d=1 b=1 v=0 io=0", done4, busy4, valid4, iter_out4);
    end
    @(posedge clk); #1;
    num4 = 4'd0;
    start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    @(negedge clk);
    total++;
    if (busy4 !== 1'b1 || done4 !== 1'b1 || pb_active4 !== '0) begin
      bad++;
      $display("FAIL w4_zero_blocks: got b=%b d=%b act=%h want b=1 d=1 act=0", busy4, done4, pb_active4);
    end
    @(posedge clk); #1;
    @(negedge clk);
    total++;
    if (busy4 !== 1'b0 || done4 !== 1'b0) begin
      bad++;
      $display("FAIL w4_back_idle: got b=%b d=%b want b=0 d=0", busy4, done4);
    end
    @(posedge clk); #1;
    mon_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
